// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: port count, arbitration pointer
// reset value, default widths and the ALU op-code encodings.
package alu_arbiter_pkg;

  localparam int       NUM_PORTS = 2;
  localparam int       XLEN_DEF  = 32;
  localparam int       TAGW_DEF  = 4;
  // Pointer starts at port 1 so that port 0 wins the first contention.
  localparam logic     LAST_RST  = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_COPY_B = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_rsp_slot.sv
// One-entry response buffer holding an ALU result and its tag.
// A load always wins over a drain, so drain-and-refill keeps valid high.
module alu_rsp_slot
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_result,
  input  logic [TAGW-1:0] i_tag,
  input  logic            i_ready,
  output logic            o_valid,
  output logic            o_free,
  output logic [XLEN-1:0] o_result,
  output logic [TAGW-1:0] o_tag
);

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [TAGW-1:0] r_tag;

  // Slot fill/drain; data only changes on a load so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_result <= i_result;
      r_tag    <= i_tag;
    end else if (i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_free   = !r_valid || i_ready;
  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_tag    = r_tag;

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU between the core pipeline
// (port 0) and an auxiliary unit (port 1). Results land one cycle later in a
// per-port response slot.
// Build option: define ALU_ARBITER_RR_EN for round-robin arbitration;
// otherwise port 0 has fixed priority on contention.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [TAGW-1:0] req1_tag,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic [TAGW-1:0] rsp0_tag,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic [TAGW-1:0] rsp1_tag,
  output logic            busy
);

  logic w_free0, w_free1;
  logic w_elig0, w_elig1;
  logic w_grant0, w_grant1;

  assign w_elig0 = req0_valid && w_free0;
  assign w_elig1 = req1_valid && w_free1;

`ifdef ALU_ARBITER_RR_EN
  logic r_last;

  // Remember the most recently granted port, updated on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= LAST_RST;
    end else if (w_grant0) begin
      r_last <= 1'b0;
    end else if (w_grant1) begin
      r_last <= 1'b1;
    end
  end

  // On contention the port that was not granted last time wins.
  always_comb begin
    w_grant0 = w_elig0 && (!w_elig1 || r_last);
    w_grant1 = w_elig1 && (!w_elig0 || !r_last);
  end
`else
  // Fixed priority: port 0 always wins contention.
  always_comb begin
    w_grant0 = w_elig0;
    w_grant1 = w_elig1 && !w_elig0;
  end
`endif

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand mux; idles on port 0's fields when nothing is granted.
  always_comb begin
    alu_op = req0_op;
    alu_a  = req0_a;
    alu_b  = req0_b;
    if (w_grant1) begin
      alu_op = req1_op;
      alu_a  = req1_a;
      alu_b  = req1_b;
    end
  end

  alu_rsp_slot #(.XLEN(XLEN), .TAGW(TAGW)) u_slot0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_grant0),
    .i_result (alu_result),
    .i_tag    (req0_tag),
    .i_ready  (rsp0_ready),
    .o_valid  (rsp0_valid),
    .o_free   (w_free0),
    .o_result (rsp0_result),
    .o_tag    (rsp0_tag)
  );

  alu_rsp_slot #(.XLEN(XLEN), .TAGW(TAGW)) u_slot1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_grant1),
    .i_result (alu_result),
    .i_tag    (req1_tag),
    .i_ready  (rsp1_ready),
    .o_valid  (rsp1_valid),
    .o_free   (w_free1),
    .o_result (rsp1_result),
    .o_tag    (rsp1_tag)
  );

  assign busy = rsp0_valid || rsp1_valid || req0_valid || req1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU in the loop.
// Works with or without ALU_ARBITER_RR_EN defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Reference ALU for the shared datapath.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change at negedge; combinational outputs checked 1 time unit later,
  // registered outputs 1 time unit after the following posedge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_op = ALU_ADD; req0_a = 0; req0_b = 0; req0_tag = 0;
    req1_valid = 0; req1_op = ALU_ADD; req1_a = 0; req1_b = 0; req1_tag = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // Reset state
    #12;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_tag", rsp1_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle mux shows port 0 fields, illegal op passes through
    req0_op = 4'hF; req0_a = 32'h1234;
    #1;
    chk("idle_alu_op", alu_op, 4'hF);
    chk("idle_alu_a", alu_a, 32'h1234);
    chk("idle_req0_ready", req0_ready, 0);

    // Single request on port 0: 5 + 7, tag 3
    @(negedge clk);
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 5; req0_b = 7; req0_tag = 3;
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    chk("single_busy", busy, 1);
    after_edge();
    chk("single_rsp0_valid", rsp0_valid, 1);
    chk("single_rsp0_result", rsp0_result, 12);
    chk("single_rsp0_tag", rsp0_tag, 3);

    // Contention, both consumers ready. Last grant went to port 0.
    for (int i = 0; i < 4; i++) begin
      logic e0, e1;
      e0 = RR ? (i % 2 == 1) : 1'b1;
      e1 = RR ? (i % 2 == 0) : 1'b0;
      @(negedge clk);
      req0_valid = 1; req0_op = ALU_ADD; req0_a = i; req0_b = 10; req0_tag = 4'(i);
      req1_valid = 1; req1_op = ALU_SUB; req1_a = 100; req1_b = i; req1_tag = 4'(i + 8);
      #1;
      chk($sformatf("cont%0d_req0_ready", i), req0_ready, e0);
      chk($sformatf("cont%0d_req1_ready", i), req1_ready, e1);
      after_edge();
      chk($sformatf("cont%0d_rsp0_valid", i), rsp0_valid, e0);
      chk($sformatf("cont%0d_rsp1_valid", i), rsp1_valid, e1);
      if (e0) chk($sformatf("cont%0d_rsp0_result", i), rsp0_result, i + 10);
      if (e1) chk($sformatf("cont%0d_rsp1_result", i), rsp1_result, 100 - i);
    end

    // Backpressure on port 1: complete 9 - 4 (tag 5) then stall the consumer
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = ALU_SUB; req1_a = 9; req1_b = 4; req1_tag = 5;
    #1;
    chk("bp_first_req1_ready", req1_ready, 1);
    after_edge();
    chk("bp_first_rsp1_result", rsp1_result, 5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rsp1_ready = 0;
      req1_op = ALU_ADD; req1_a = 1; req1_b = 1; req1_tag = 6;
      req0_valid = 1; req0_op = ALU_ADD; req0_a = 2; req0_b = 3 + k; req0_tag = 4'(k);
      #1;
      chk($sformatf("bp%0d_req1_ready", k), req1_ready, 0);
      chk($sformatf("bp%0d_req0_ready", k), req0_ready, 1);
      after_edge();
      chk($sformatf("bp%0d_rsp1_valid", k), rsp1_valid, 1);
      chk($sformatf("bp%0d_rsp1_result", k), rsp1_result, 5);
      chk($sformatf("bp%0d_rsp1_tag", k), rsp1_tag, 5);
      chk($sformatf("bp%0d_rsp0_result", k), rsp0_result, 5 + k);
    end
    @(negedge clk);
    req0_valid = 0; rsp1_ready = 1;
    #1;
    chk("bp_release_req1_ready", req1_ready, 1);
    after_edge();
    chk("bp_release_rsp1_result", rsp1_result, 2);
    chk("bp_release_rsp1_tag", rsp1_tag, 6);

    // Drain-and-refill on port 0 with SLT -1 < 0
    @(negedge clk);
    req1_valid = 0;
    rsp0_ready = 0;
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 1; req0_tag = 1;
    after_edge();
    chk("dr_fill_result", rsp0_result, 2);
    @(negedge clk);
    #1;
    chk("dr_full_req0_ready", req0_ready, 0);
    rsp0_ready = 1;
    req0_op = ALU_SLT; req0_a = 32'hFFFF_FFFF; req0_b = 0; req0_tag = 2;
    #1;
    chk("dr_req0_ready", req0_ready, 1);
    after_edge();
    chk("dr_rsp0_valid", rsp0_valid, 1);
    chk("dr_rsp0_result", rsp0_result, 1);
    chk("dr_rsp0_tag", rsp0_tag, 2);
    @(negedge clk);
    req0_valid = 0;
    after_edge();
    chk("drain_rsp0_valid", rsp0_valid, 0);

    // Reset mid-flight with both slots full
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 2; req0_tag = 7;
    req1_valid = 1; req1_op = ALU_ADD; req1_a = 3; req1_b = 4; req1_tag = 9;
    repeat (2) @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("mf_rsp0_valid", rsp0_valid, 1);
    chk("mf_rsp1_valid", rsp1_valid, 1);
    chk("mf_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mf_rst_rsp0_valid", rsp0_valid, 0);
    chk("mf_rst_rsp1_valid", rsp1_valid, 0);
    chk("mf_rst_busy", busy, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_req0_ready", req0_ready, 1);
    chk("post_rst_req1_ready", req1_ready, 0);
    @(negedge clk);
    #1;
    chk("post_rst2_req1_ready", req1_ready, RR ? 1 : 0);
    req0_valid = 0; req1_valid = 0;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters: port 0 is the core pipeline and port 1 is an auxiliary unit such as a CSR or debug engine. Each port has a valid/ready request channel and a valid/ready response channel. The arbiter grants at most one request per cycle and drives the winning operands and 4-bit ALU op code onto the shared ALU. It captures the ALU result into a one-entry response slot owned by the winning port. It sits between the requesters and the existing ALU/ALU-decoder datapath and adds one cycle of latency.

## Interface
- XLEN, 32, operand and result width
- TAGW, 4, width of the opaque request tag returned with each result

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  (N = 0, 1) request present
- reqN_ready  out  1  request accepted this cycle when high together with reqN_valid
- reqN_op  in  4  ALU op code, using the `ALU_*` encodings
- reqN_a, reqN_b  in  XLEN  operands
- reqN_tag  in  TAGW  opaque tag
- alu_op  out  4  op code driven to the shared ALU
- alu_a, alu_b  out  XLEN  operands driven to the shared ALU
- alu_result  in  XLEN  combinational ALU result, same cycle as alu_op/alu_a/alu_b
- rspN_valid  out  1  response slot N full
- rspN_ready  in  1  consumer accepts response N
- rspN_result  out  XLEN  captured result
- rspN_tag  out  TAGW  tag of the captured request
- busy  out  1  any rspN_valid high, or any reqN_valid high

## Operation
- Slot N can accept a request when `slot_freeN = !rspN_valid || rspN_ready`.
- Port N is eligible when `eligN = reqN_valid && slot_freeN`.
- Grant:
  - Only one eligible port: that port wins.
  - Both eligible: the arbitration policy decides (see Configuration).
  - Neither eligible: no grant.
- `reqN_ready = grantN`. ready depends combinationally on valid and rspN_ready, so a requester must never gate valid on ready.
- ALU drive:
  - The mux selects the granted port's op and operands.
  - With no grant, the mux selects port 0's fields. The ALU output is then ignored.
  - The op code is passed through unchecked; illegal codes produce whatever the ALU produces.
- On a grant to port N at a clock edge:
  - rspN_result is loaded from alu_result and rspN_tag from reqN_tag.
  - rspN_valid is set.
- Drain and refill in the same cycle (rspN_valid && rspN_ready && grantN): the slot is reloaded and rspN_valid stays high.
- Drain with no refill: rspN_valid clears.
- While rspN_valid is high and rspN_ready is low, rspN_result and rspN_tag hold stable.
- A response slot is never overwritten, and a result is never dropped or duplicated.

## Timing
- Latency: a request handshake at edge k gives rspN_valid high after edge k, with data valid in that cycle.
- Aggregate throughput: one operation per cycle. Per-port throughput: one per cycle when rspN_ready is held high.
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - rspN_result = 0, rspN_tag = 0.
  - Arbitration pointer `last` = 1, so port 0 wins the first contention.
  - busy follows from the above.
- Reset asserted mid-operation: all slots clear immediately (asynchronously) and pending results are lost. Requesters must re-issue after rst_n deasserts.
- The first grant can occur in the first cycle after rst_n deasserts.

## Configuration
- ALU_ARBITER_RR_EN defined:
  - Round-robin arbitration. On contention, the port with index != `last` wins.
  - `last` updates to the granted index on every grant, contended or not.
  - Worst-case wait for a continuously eligible port is 1 cycle.
- ALU_ARBITER_RR_EN undefined:
  - Fixed priority: port 0 always wins contention, and the `last` register is not instantiated.
  - Port 1 can starve. This is acceptable because port 1 is low-rate.

## Structure
- Put port count, the reset value of `last`, and XLEN/TAGW defaults in a shared header ALUarb.vh, alongside the existing ALUop.vh/Opcode.vh. Op encodings come from ALUop.vh only.
- Sub-module alu_rsp_slot: a one-entry response buffer (load, valid, ready, data, tag) with asynchronous reset. It is instantiated once per port.
- The arbitration logic and operand mux stay in alu_arbiter.

## Test plan
- Single request, port 0: ALU_ADD, a=5, b=7, tag=3, rsp0_ready=1 -> req0_ready=1 at edge 0; next cycle rsp0_valid=1, result=12, tag=3.
- Contention with ALU_ARBITER_RR_EN defined: both ports valid every cycle, both rsp_ready=1 -> grants alternate 0,1,0,1. Without the macro: port 0 is granted every cycle and req1_ready stays 0.
- Backpressure: port 1 completes an ALU_SUB 9-4, then rsp1_ready=0 for 3 cycles while req1_valid=1 -> req1_ready=0 for those 3 cycles and rsp1_result holds 5. Port 0 requests continue to be granted.
- Drain-and-refill: rsp0_valid=1, rsp0_ready=1, req0 ALU_SLT a=-1, b=0 -> rsp0_valid stays 1 and the next result is 1.
- Reset mid-flight: both slots full, rst_n pulsed low between edges -> rsp0_valid, rsp1_valid and busy drop immediately. After release, the first contention is granted to port 0.
